// File: rtl/cpu_top.sv
// cpu_top: single-cycle RV32I core with private instruction and data memories.
// One instruction retires per clock edge. The state is observed through pc_q, rf, imem and dmem.
// imem is a read-only array that the environment loads through the hierarchy
// (IMEM_INIT names the image that the load flow uses). The core itself never writes imem.
module cpu_top #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter string       IMEM_INIT  = "program.hex"
) (
  input  logic clk,
  input  logic reset_n   // active-high asynchronous reset despite the name
);

  localparam int unsigned IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Architectural state (names are relied upon for hierarchical probing)
  logic [31:0] pc_q;
  logic [31:0] rf   [0:31];
  logic [31:0] imem [0:IMEM_DEPTH-1];
  logic [31:0] dmem [0:DMEM_DEPTH-1];

  // Fetch / decode
  logic [IMEM_AW-1:0] w_imem_idx;
  logic [31:0]        w_instr;
  logic [6:0]         w_opcode;
  logic [4:0]         w_rd;
  logic [4:0]         w_rs1;
  logic [4:0]         w_rs2;
  logic [2:0]         w_funct3;
  logic [31:0]        w_imm_i;
  logic [31:0]        w_imm_s;
  logic [31:0]        w_imm_b;
  logic [31:0]        w_imm_u;
  logic [31:0]        w_imm_j;
  logic [31:0]        w_rs1_val;
  logic [31:0]        w_rs2_val;
  logic [31:0]        w_pc_plus4;

  // Execute / memory
  logic               w_br_taken;
  logic [31:0]        w_addr;
  logic [DMEM_AW-1:0] w_dmem_idx;
  logic [31:0]        w_ld_word;
  logic [7:0]         w_ld_byte;
  logic [15:0]        w_ld_half;
  logic [31:0]        w_ld_data;
  logic               w_ld_ok;

  // Commit controls
  logic [31:0]        w_next_pc;
  logic               w_rd_we;
  logic [31:0]        w_rd_data;
  logic               w_mem_we;
  logic [3:0]         w_mem_mask;
  logic [31:0]        w_mem_wdata;

  // 32-bit ALU shared by OP and OP-IMM; sub/sra select the alternate encodings
  function automatic logic [31:0] alu_op(input logic [2:0]  f3,
                                         input logic        sub,
                                         input logic        sra,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (f3)
      3'b000: r = sub ? (a - b) : (a + b);
      3'b001: r = a << b[4:0];
      3'b010: r = {31'b0, ($signed(a) < $signed(b))};
      3'b011: r = {31'b0, (a < b)};
      3'b100: r = a ^ b;
      3'b101: r = sra ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Fetch and field extraction; fetch ignores pc bits [1:0]
  always_comb begin
    w_imem_idx = IMEM_AW'({2'b00, pc_q[31:2]} % IMEM_DEPTH);
    w_instr    = imem[w_imem_idx];
    w_opcode   = w_instr[6:0];
    w_rd       = w_instr[11:7];
    w_funct3   = w_instr[14:12];
    w_rs1      = w_instr[19:15];
    w_rs2      = w_instr[24:20];
    w_imm_i    = {{20{w_instr[31]}}, w_instr[31:20]};
    w_imm_s    = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    w_imm_b    = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    w_imm_u    = {w_instr[31:12], 12'b0};
    w_imm_j    = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
    w_rs1_val  = (w_rs1 == 5'd0) ? 32'd0 : rf[w_rs1];
    w_rs2_val  = (w_rs2 == 5'd0) ? 32'd0 : rf[w_rs2];
    w_pc_plus4 = pc_q + 32'd4;
  end

  // Branch condition evaluation
  always_comb begin
    w_br_taken = 1'b0;
    case (w_funct3)
      3'b000: w_br_taken = (w_rs1_val == w_rs2_val);
      3'b001: w_br_taken = (w_rs1_val != w_rs2_val);
      3'b100: w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'b101: w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'b110: w_br_taken = (w_rs1_val <  w_rs2_val);
      3'b111: w_br_taken = (w_rs1_val >= w_rs2_val);
      default: w_br_taken = 1'b0;
    endcase
  end

  // Data memory address and combinational load formatting
  always_comb begin
    w_addr     = w_rs1_val + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
    w_dmem_idx = DMEM_AW'({2'b00, w_addr[31:2]} % DMEM_DEPTH);
    w_ld_word  = dmem[w_dmem_idx];
    w_ld_byte  = w_ld_word[{w_addr[1:0], 3'b000} +: 8];
    w_ld_half  = w_addr[1] ? w_ld_word[31:16] : w_ld_word[15:0];
    w_ld_ok    = 1'b1;
    w_ld_data  = '0;
    case (w_funct3)
      3'b000: w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001: w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b010: w_ld_data = w_ld_word;
      3'b100: w_ld_data = {24'b0, w_ld_byte};
      3'b101: w_ld_data = {16'b0, w_ld_half};
      default: w_ld_ok  = 1'b0;
    endcase
  end

  // Per-opcode commit controls; unknown opcodes fall through as a NOP
  always_comb begin
    w_next_pc   = w_pc_plus4;
    w_rd_we     = 1'b0;
    w_rd_data   = '0;
    w_mem_we    = 1'b0;
    w_mem_mask  = 4'b0000;
    w_mem_wdata = '0;
    case (w_opcode)
      OP_LUI: begin
        w_rd_we   = 1'b1;
        w_rd_data = w_imm_u;
      end
      OP_AUIPC: begin
        w_rd_we   = 1'b1;
        w_rd_data = pc_q + w_imm_u;
      end
      OP_JAL: begin
        w_rd_we   = 1'b1;
        w_rd_data = w_pc_plus4;
        w_next_pc = pc_q + w_imm_j;
      end
      OP_JALR: begin
        w_rd_we   = 1'b1;
        w_rd_data = w_pc_plus4;
        w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        if (w_br_taken) w_next_pc = pc_q + w_imm_b;
      end
      OP_LOAD: begin
        w_rd_we   = w_ld_ok;
        w_rd_data = w_ld_data;
      end
      OP_STORE: begin
        case (w_funct3)
          3'b000: begin
            w_mem_we    = 1'b1;
            w_mem_mask  = 4'b0001 << w_addr[1:0];
            w_mem_wdata = {4{w_rs2_val[7:0]}};
          end
          3'b001: begin
            w_mem_we    = 1'b1;
            w_mem_mask  = w_addr[1] ? 4'b1100 : 4'b0011;
            w_mem_wdata = {2{w_rs2_val[15:0]}};
          end
          3'b010: begin
            w_mem_we    = 1'b1;
            w_mem_mask  = 4'b1111;
            w_mem_wdata = w_rs2_val;
          end
          default: w_mem_we = 1'b0;
        endcase
      end
      OP_IMM: begin
        w_rd_we   = 1'b1;
        w_rd_data = alu_op(w_funct3, 1'b0, w_instr[30], w_rs1_val, w_imm_i);
      end
      OP_REG: begin
        w_rd_we   = 1'b1;
        w_rd_data = alu_op(w_funct3, w_instr[30], w_instr[30], w_rs1_val, w_rs2_val);
      end
      default: w_rd_we = 1'b0;
    endcase
  end

  // Program counter register
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) pc_q <= RESET_PC;
    else         pc_q <= w_next_pc;
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (w_rd_we && (w_rd != 5'd0)) begin
      rf[w_rd] <= w_rd_data;
    end
  end

  // Byte-lane data memory write port; contents are kept across reset
  always_ff @(posedge clk) begin
    if (!reset_n && w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mem_mask[b]) dmem[w_dmem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top: programs are written into imem through the hierarchy.
module tb_cpu_top;

  logic clk;
  logic reset_n;

  int n_total;
  int n_passed;

  cpu_top dut (
    .clk     (clk),
    .reset_n (reset_n)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) dut.imem[i] = NOP;
  endtask

  task automatic check_prog_a(input string sfx);
    chk({"x1",  sfx}, dut.rf[1],  32'd5);
    chk({"x2",  sfx}, dut.rf[2],  32'hFFFF_FFFD);
    chk({"x3",  sfx}, dut.rf[3],  32'd2);
    chk({"x4",  sfx}, dut.rf[4],  32'hFFFF_FFF8);
    chk({"x5",  sfx}, dut.rf[5],  32'd1);
    chk({"x6",  sfx}, dut.rf[6],  32'hFFFF_FFFE);
    chk({"x7",  sfx}, dut.rf[7],  32'h1234_5678);
    chk({"x8",  sfx}, dut.rf[8],  32'h0000_0078);
    chk({"x9",  sfx}, dut.rf[9],  32'h0000_1234);
    chk({"x10", sfx}, dut.rf[10], 32'h0534_5678);
    chk({"x11", sfx}, dut.rf[11], 32'd1);
    chk({"x12", sfx}, dut.rf[12], 32'h0000_000F);
    chk({"x13", sfx}, dut.rf[13], 32'hFFFF_FFFD);
    chk({"x14", sfx}, dut.rf[14], 32'h0000_00FF);
    chk({"x0",  sfx}, dut.rf[0],  32'd0);
    chk({"pc",  sfx}, dut.pc_q,   32'h48);
  endtask

  initial begin
    n_total  = 0;
    n_passed = 0;
    clk      = 1'b0;
    reset_n  = 1'b1;

    // Program A: ALU, loads/stores, then a self-loop at 0x48
    clear_imem();
    dut.imem[0]  = enc_i(32'd5,          5'd0, 3'b000, 5'd1,  7'b0010011); // addi x1,x0,5
    dut.imem[1]  = enc_i(-32'sd3,        5'd0, 3'b000, 5'd2,  7'b0010011); // addi x2,x0,-3
    dut.imem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);                 // add x3,x1,x2
    dut.imem[3]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4);                 // sub x4,x2,x1
    dut.imem[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd5);                 // sltu x5,x1,x2
    dut.imem[5]  = enc_i(32'h401,        5'd2, 3'b101, 5'd6,  7'b0010011); // srai x6,x2,1
    dut.imem[6]  = {20'h12345, 5'd7, 7'b0110111};                          // lui x7,0x12345
    dut.imem[7]  = enc_i(32'h678,        5'd7, 3'b000, 5'd7,  7'b0010011); // addi x7,x7,0x678
    dut.imem[8]  = enc_s(32'd8,  5'd7, 5'd0, 3'b010);                      // sw x7,8(x0)
    dut.imem[9]  = enc_i(32'd8,          5'd0, 3'b000, 5'd8,  7'b0000011); // lb x8,8(x0)
    dut.imem[10] = enc_i(32'd10,         5'd0, 3'b101, 5'd9,  7'b0000011); // lhu x9,10(x0)
    dut.imem[11] = enc_s(32'd11, 5'd1, 5'd0, 3'b000);                      // sb x1,11(x0)
    dut.imem[12] = enc_i(32'd8,          5'd0, 3'b010, 5'd10, 7'b0000011); // lw x10,8(x0)
    dut.imem[13] = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd11);                // slt x11,x2,x1
    dut.imem[14] = enc_i(32'd28,         5'd2, 3'b101, 5'd12, 7'b0010011); // srli x12,x2,28
    dut.imem[15] = enc_s(32'd12, 5'd2, 5'd0, 3'b001);                      // sh x2,12(x0)
    dut.imem[16] = enc_i(32'd12,         5'd0, 3'b001, 5'd13, 7'b0000011); // lh x13,12(x0)
    dut.imem[17] = enc_i(32'd13,         5'd0, 3'b100, 5'd14, 7'b0000011); // lbu x14,13(x0)
    dut.imem[18] = enc_j(32'd0, 5'd0);                                     // jal x0,0

    #2;
    chk("pc_in_reset", dut.pc_q, 32'h0);
    chk("x1_in_reset", dut.rf[1], 32'h0);
    #8;
    reset_n = 1'b0;

    step(1);
    chk("pc_first_edge", dut.pc_q, 32'h4);
    chk("x1_first_edge", dut.rf[1], 32'd5);
    step(17);
    check_prog_a("_a");
    step(200);
    check_prog_a("_loop");

    // Mid-program reset: pc and registers clear at once, dmem is retained
    #3;
    reset_n = 1'b1;
    #1;
    chk("pc_mid_reset", dut.pc_q, 32'h0);
    chk("x7_mid_reset", dut.rf[7], 32'h0);
    chk("dmem2_kept", dut.dmem[2], 32'h0534_5678);

    // Program B: branches
    clear_imem();
    dut.imem[0]  = enc_i(32'd5,   5'd0, 3'b000, 5'd1, 7'b0010011); // addi x1,x0,5
    dut.imem[1]  = enc_i(-32'sd3, 5'd0, 3'b000, 5'd2, 7'b0010011); // addi x2,x0,-3
    dut.imem[2]  = enc_b(32'd8, 5'd1, 5'd1, 3'b000);               // beq x1,x1,+8
    dut.imem[3]  = enc_i(32'd1,   5'd0, 3'b000, 5'd3, 7'b0010011); // addi x3,x0,1 (skipped)
    dut.imem[4]  = enc_b(32'd8, 5'd1, 5'd1, 3'b001);               // bne x1,x1,+8
    dut.imem[5]  = enc_i(32'd1,   5'd0, 3'b000, 5'd4, 7'b0010011); // addi x4,x0,1
    dut.imem[6]  = enc_b(32'd8, 5'd1, 5'd2, 3'b100);               // blt x2,x1,+8
    dut.imem[7]  = enc_i(32'd1,   5'd0, 3'b000, 5'd5, 7'b0010011); // addi x5,x0,1 (skipped)
    dut.imem[8]  = enc_b(32'd8, 5'd1, 5'd2, 3'b110);               // bltu x2,x1,+8
    dut.imem[9]  = enc_i(32'd1,   5'd0, 3'b000, 5'd6, 7'b0010011); // addi x6,x0,1
    dut.imem[10] = enc_j(32'd0, 5'd0);                             // jal x0,0

    @(negedge clk);
    reset_n = 1'b0;
    step(2);
    chk("pc_before_beq", dut.pc_q, 32'h8);
    step(1);
    chk("pc_beq_taken", dut.pc_q, 32'h10);
    step(1);
    chk("pc_bne_fall", dut.pc_q, 32'h14);
    step(2);
    chk("pc_blt_taken", dut.pc_q, 32'h20);
    step(1);
    chk("pc_bltu_fall", dut.pc_q, 32'h24);
    step(2);
    chk("pc_b_loop", dut.pc_q, 32'h28);
    chk("x3_skipped", dut.rf[3], 32'd0);
    chk("x4_executed", dut.rf[4], 32'd1);
    chk("x5_skipped", dut.rf[5], 32'd0);
    chk("x6_executed", dut.rf[6], 32'd1);

    // Program C: jumps and x0 write discard
    @(negedge clk);
    reset_n = 1'b1;
    clear_imem();
    dut.imem[0]  = enc_i(32'd1, 5'd0, 3'b000, 5'd0, 7'b0010011);   // addi x0,x0,1
    dut.imem[8]  = enc_j(32'd12, 5'd1);                            // jal x1,+12
    dut.imem[9]  = enc_i(32'd7, 5'd0, 3'b000, 5'd2, 7'b0010011);   // addi x2,x0,7
    dut.imem[10] = enc_j(32'd0, 5'd0);                             // jal x0,0
    dut.imem[11] = enc_i(32'd0, 5'd1, 3'b000, 5'd0, 7'b1100111);   // jalr x0,0(x1)
    @(negedge clk);
    reset_n = 1'b0;
    step(1);
    chk("x0_discard", dut.rf[0], 32'd0);
    chk("pc_after_x0", dut.pc_q, 32'h4);
    step(7);
    chk("pc_at_jal", dut.pc_q, 32'h20);
    step(1);
    chk("pc_jal", dut.pc_q, 32'h2C);
    chk("x1_link", dut.rf[1], 32'h24);
    step(1);
    chk("pc_jalr", dut.pc_q, 32'h24);
    step(1);
    chk("x2_after_jalr", dut.rf[2], 32'd7);
    step(5);
    chk("pc_c_loop", dut.pc_q, 32'h28);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
